// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage:
// FSM encoding, default reset PC and instruction field helpers.
package if_stage_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int FUN_MSB = 5;
    localparam int FUN_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    function automatic logic [5:0] opcode_of(input logic [31:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] ins);
        return ins[FUN_MSB:FUN_LSB];
    endfunction

    function automatic logic [25:0] tgt26_of(input logic [31:0] ins);
        return ins[TGT_MSB:0];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch
// stage (master) and instruction memory (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_npc_calc.sv
// Next-PC selection: jump target, taken branch, or sequential.
// Only the low 26 instruction bits feed the target arithmetic.
module npc_calc
    import if_stage_pkg::*;
(
    input  logic [31:0]      pc_plus4_i,
    input  logic [TGT_MSB:0] instr_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             zero_i,
    output logic [31:0]      npc_o
);

    logic [31:0] br_off;
    logic [31:0] j_tgt;

    assign br_off = {{14{instr_i[IMM_MSB]}}, instr_i[IMM_MSB:0], 2'b00};
    assign j_tgt  = {pc_plus4_i[31:28], instr_i, 2'b00};

    // jump outranks a simultaneous taken branch
    always_comb begin
        npc_o = pc_plus4_i;
        if (jump_i) begin
            npc_o = j_tgt;
        end else if (branch_i && zero_i) begin
            npc_o = pc_plus4_i + br_off;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PC, fetched instruction and
// retired count; hands the instruction to Ctrl until acked.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  imem,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] npc;

    npc_calc u_npc (
        .pc_plus4_i (pc_plus4),
        .instr_i    (tgt26_of(instr_q)),
        .jump_i     (jump),
        .branch_i   (Branch),
        .zero_i     (Zero),
        .npc_o      (npc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    pc_d      = npc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign OpCode      = opcode_of(instr_q);
    assign funct       = funct_of(instr_q);
    assign instr_valid = (state_q == ST_HOLD);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign retired     = retired_q;

endmodule
